// File: rtl/sobel_magnitude.sv
// rtl/sobel_magnitude.sv - L1 gradient magnitude with scale, saturation, edge threshold and frame position
// Three-stage valid/ready pipeline; all stages shift together on advance so bubbles are preserved.
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16,
  parameter int SHIFT_P  = 0
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic [WIDTH_P-1:0]          threshold_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [WIDTH_P-1:0]          data_o,
  output logic                        edge_o,
  output logic                        last_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = (DEPTH_P > 2) ? $clog2(DEPTH_P) : 2;
  localparam int RW = (HEIGHT_P > 2) ? $clog2(HEIGHT_P) : 2;
  localparam logic [GW:0] MAX_C = {{(WIDTH_P + 1){1'b0}}, {WIDTH_P{1'b1}}};

  logic          advance;
  logic          xfer_in;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          v1, border1, last1;
  logic [GW-1:0] ax1, ay1;
  logic          v2, border2, last2;
  logic [WIDTH_P-1:0] mag2;

  logic [GW:0]        sum;
  logic [GW:0]        shifted;
  logic [WIDTH_P-1:0] mag_next;

  // Unsigned result is one bit wider in meaning than the signed range, so the most negative value does not wrap.
  function automatic logic [GW-1:0] abs_f(input logic [GW-1:0] v);
    return v[GW-1] ? (~v + GW'(1)) : v;
  endfunction

  assign advance = ready_i | ~valid_o;
  assign ready_o = advance;
  assign xfer_in = valid_i & advance;

  assign sum      = {1'b0, ax1} + {1'b0, ay1};
  assign shifted  = sum >> SHIFT_P;
  assign mag_next = border1 ? '0 : ((shifted > MAX_C) ? '1 : shifted[WIDTH_P-1:0]);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col <= '0;
      row <= '0;
    end else if (xfer_in) begin
      if (col == CW'(DEPTH_P - 1)) begin
        col <= '0;
        row <= (row == RW'(HEIGHT_P - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1      <= 1'b0;
      ax1     <= '0;
      ay1     <= '0;
      border1 <= 1'b0;
      last1   <= 1'b0;
      v2      <= 1'b0;
      mag2    <= '0;
      border2 <= 1'b0;
      last2   <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      edge_o  <= 1'b0;
      last_o  <= 1'b0;
    end else if (advance) begin
      v1      <= valid_i;
      ax1     <= abs_f(gx_i);
      ay1     <= abs_f(gy_i);
      border1 <= (col < CW'(2)) | (row < RW'(2));
      last1   <= (col == CW'(DEPTH_P - 1)) & (row == RW'(HEIGHT_P - 1));

      v2      <= v1;
      mag2    <= mag_next;
      border2 <= border1;
      last2   <= last1;

      valid_o <= v2;
      data_o  <= mag2;
      edge_o  <= (mag2 >= threshold_i) & ~border2;
      last_o  <= last2;
    end
  end

endmodule
